// File: rtl/value_capture_fifo_pkg.sv
// rtl/value_capture_fifo_pkg.sv - shared sizing constants for the enable/value capture path
package value_capture_fifo_pkg;

    localparam int VCF_WIDTH = 8;
    localparam int VCF_DEPTH = 4;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/value_capture_fifo.sv
// rtl/value_capture_fifo.sv - captures strobed values into a first-word-fall-through queue
module value_capture_fifo
    import value_capture_fifo_pkg::*;
#(
    parameter int WIDTH = VCF_WIDTH,
    parameter int DEPTH = VCF_DEPTH
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_en,
    input  logic [WIDTH-1:0]                i_value,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [WIDTH-1:0]                o_value,
    output logic [count_width(DEPTH)-1:0]   o_count,
    output logic                            o_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("value_capture_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             pop;
    logic             push;

    // A full queue still accepts a strobe when the head leaves in the same cycle.
    always_comb begin
        pop  = o_valid & i_ready;
        push = i_en & ((count != FULL) | pop);
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_value;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (i_en && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        o_valid    = (count != '0);
        o_value    = o_valid ? mem[rd_ptr] : '0;
        o_count    = count;
        o_overflow = overflow;
    end

endmodule

// File: tb/tb_value_capture_fifo.sv
// tb/tb_value_capture_fifo.sv - randomized and directed checks against a queue model
module tb_value_capture_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] value;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] head;
    logic [2:0]       count;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] model_q[$];
    logic             model_ovf;

    always #5 clk = ~clk;

    value_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_value    (value),
        .o_valid    (valid),
        .i_ready    (ready),
        .o_value    (head),
        .o_count    (count),
        .o_overflow (overflow)
    );

    // Drive one cycle, advance the reference model, and return #1 after the edge.
    task automatic tick(input logic r, input logic e, input logic [WIDTH-1:0] v, input logic rd);
        bit do_pop;
        bit do_push;
        rst   = r;
        en    = e;
        value = v;
        ready = rd;
        if (r) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            do_pop  = (model_q.size() != 0) && rd;
            do_push = e && ((model_q.size() != DEPTH) || do_pop);
            if (do_pop)
                void'(model_q.pop_front());
            if (do_push)
                model_q.push_back(v);
            if (e && !do_push)
                model_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b0;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 8'h5A, 1'b0);
        n_checks++;
        if (valid !== 1'b0 || head !== 8'h00 || count !== 3'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got valid=%b value=%h count=%0d ovf=%b exp 0 00 0 0", valid, head, count, overflow);
        end
    endtask

    task automatic test_capture();
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 1'b1, 8'h11, 1'b0);
        n_checks++;
        if (valid !== 1'b1 || head !== 8'h11) begin
            n_fail++;
            $display("FAIL capture_latency got valid=%b value=%h exp 1 11", valid, head);
        end
        tick(1'b0, 1'b1, 8'h22, 1'b0);
        tick(1'b0, 1'b1, 8'h33, 1'b0);
        n_checks++;
        if (count !== 3'd3 || head !== 8'h11 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL capture_three got count=%0d value=%h ovf=%b exp 3 11 0", count, head, overflow);
        end
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] exp;
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < DEPTH; i++)
            tick(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
        n_checks++;
        if (overflow !== 1'b0 || count !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_before_drop got ovf=%b count=%0d exp 0 4", overflow, count);
        end
        tick(1'b0, 1'b1, 8'hFF, 1'b0);
        n_checks++;
        if (overflow !== 1'b1 || count !== 3'd4 || head !== 8'hA0) begin
            n_fail++;
            $display("FAIL ovf_drop got ovf=%b count=%0d value=%h exp 1 4 a0", overflow, count, head);
        end
        for (int i = 0; i < DEPTH; i++) begin
            exp = 8'hA0 + 8'(i);
            n_checks++;
            if (valid !== 1'b1 || head !== exp) begin
                n_fail++;
                $display("FAIL ovf_drain[%0d] got valid=%b value=%h exp 1 %h", i, valid, head, exp);
            end
            tick(1'b0, 1'b0, 8'h00, 1'b1);
        end
        n_checks++;
        if (valid !== 1'b0 || head !== 8'h00 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_empty_sticky got valid=%b value=%h ovf=%b exp 0 00 1", valid, head, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [WIDTH-1:0] exp_seq[4] = '{8'hA1, 8'hA2, 8'hA3, 8'h55};
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < DEPTH; i++)
            tick(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
        tick(1'b0, 1'b1, 8'h55, 1'b1);
        n_checks++;
        if (count !== 3'd4 || overflow !== 1'b0 || head !== 8'hA1) begin
            n_fail++;
            $display("FAIL full_push_pop got count=%0d ovf=%b value=%h exp 4 0 a1", count, overflow, head);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (head !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL full_drain[%0d] got %h exp %h", i, head, exp_seq[i]);
            end
            tick(1'b0, 1'b0, 8'h00, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 1'b1, 8'h00, 1'b1);
        for (int i = 1; i < 10; i++) begin
            n_checks++;
            if (valid !== 1'b1 || head !== 8'(i - 1) || count !== 3'd1) begin
                n_fail++;
                $display("FAIL stream[%0d] got valid=%b value=%h count=%0d exp 1 %h 1", i, valid, head, count, 8'(i - 1));
            end
            tick(1'b0, 1'b1, 8'(i), 1'b1);
        end
        n_checks++;
        if (head !== 8'h09 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL stream_last got value=%h count=%0d exp 09 1", head, count);
        end
    endtask

    task automatic test_empty_no_bypass();
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 1'b1, 8'h3C, 1'b1);
        n_checks++;
        if (valid !== 1'b1 || head !== 8'h3C || count !== 3'd1) begin
            n_fail++;
            $display("FAIL no_bypass got valid=%b value=%h count=%0d exp 1 3c 1", valid, head, count);
        end
    endtask

    task automatic test_reset_midstream();
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < DEPTH; i++)
            tick(1'b0, 1'b1, 8'hC0 + 8'(i), 1'b0);
        tick(1'b0, 1'b1, 8'hEE, 1'b0);
        tick(1'b1, 1'b1, 8'h99, 1'b0);
        n_checks++;
        if (valid !== 1'b0 || head !== 8'h00 || count !== 3'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset got valid=%b value=%h count=%0d ovf=%b exp 0 00 0 0", valid, head, count, overflow);
        end
        tick(1'b0, 1'b1, 8'h77, 1'b0);
        n_checks++;
        if (valid !== 1'b1 || head !== 8'h77 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL after_reset_push got valid=%b value=%h count=%0d exp 1 77 1", valid, head, count);
        end
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_sole got valid=%b exp 0", valid);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] exp_val;
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
                 8'($urandom), ($urandom_range(0, 1) == 1));
            exp_val = (model_q.size() != 0) ? model_q[0] : 8'h00;
            n_checks++;
            if (valid !== (model_q.size() != 0) || head !== exp_val ||
                count !== 3'(model_q.size()) || overflow !== model_ovf) begin
                n_fail++;
                $display("FAIL random[%0d] got valid=%b value=%h count=%0d ovf=%b exp %b %h %0d %b",
                         i, valid, head, count, overflow, (model_q.size() != 0), exp_val,
                         model_q.size(), model_ovf);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        value     = '0;
        ready     = 1'b0;
        model_ovf = 1'b0;
        test_reset();
        test_capture();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_empty_no_bypass();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
